// File: rtl/wb_pkg.sv
// wb_pkg: shared writeback-control bit indices, register-zero constant and arbiter FSM encoding
package wb_pkg;
  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;
  localparam logic [4:0] REG_ZERO = 5'd0;
  typedef enum logic [1:0] {IDLE = 2'd0, PEND = 2'd1, STALL = 2'd2} state_t;
endpackage

// File: rtl/wb_port_arbiter_if.sv
// wb_port_arbiter_if: MEM/WB, long-unit, register-file and hazard signals around the write-port arbiter (slave = arbiter side)
interface wb_port_arbiter_if;
  logic [1:0]  WB_WB;
  logic [31:0] WB_DM_out;
  logic [31:0] WB_ALU_out;
  logic [4:0]  WB_writeReg;
  logic        lu_valid;
  logic [31:0] lu_data;
  logic [4:0]  lu_reg;
  logic        lu_ready;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        stall_req;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        pend_rs;
  logic        pend_rt;
  modport slave (
    input  WB_WB, WB_DM_out, WB_ALU_out, WB_writeReg, lu_valid, lu_data, lu_reg, id_rs, id_rt,
    output lu_ready, rf_we, rf_waddr, rf_wdata, stall_req, pend_rs, pend_rt
  );
  modport master (
    output WB_WB, WB_DM_out, WB_ALU_out, WB_writeReg, lu_valid, lu_data, lu_reg, id_rs, id_rt,
    input  lu_ready, rf_we, rf_waddr, rf_wdata, stall_req, pend_rs, pend_rt
  );
endinterface

// File: rtl/wb_fifo.sv
// wb_fifo: sync FIFO of {reg[4:0], data[31:0]} with count/full/empty, active-low sync rst, and two parallel register-match queries
module wb_fifo import wb_pkg::*; #(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [36:0]   wdata,
  output logic [36:0]   rdata,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty,
  input  logic [4:0]    q0,
  input  logic [4:0]    q1,
  output logic          m0,
  output logic          m1
);
  logic [36:0]      mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]      count_q, count_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  always_comb begin
    wr_d = push ? wr_q + 1'b1 : wr_q;
    rd_d = pop ? rd_q + 1'b1 : rd_q;
    count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
    valid_d = valid_q;
    if (pop) valid_d[rd_q] = 1'b0;
    if (push) valid_d[wr_q] = 1'b1;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end
  always_ff @(posedge clk) if (push) mem_q[wr_q] <= wdata;
  // per-slot valid bits let the hazard match ignore stale storage without pointer arithmetic
  always_comb begin
    m0 = 1'b0;
    m1 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      m0 = m0 | (valid_q[i] && mem_q[i][36:32] == q0 && q0 != REG_ZERO);
      m1 = m1 | (valid_q[i] && mem_q[i][36:32] == q1 && q1 != REG_ZERO);
    end
  end
  assign rdata = mem_q[rd_q];
  assign count = count_q;
  assign full  = count_q == (AW+1)'(DEPTH);
  assign empty = count_q == '0;
endmodule

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the RF write port between MEM/WB (priority) and queued long-unit results; clk, active-low sync rst, bus = slave modport
module wb_port_arbiter import wb_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int STARVE_MAX = 8
) (
  input logic clk,
  input logic rst,
  wb_port_arbiter_if.slave bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);
  logic [36:0]   head;
  logic [CW-1:0] count, cnt_nxt;
  logic          full, empty, pipe_we, pop, keep;
  logic [SW-1:0] starve_q, starve_d;
  state_t        state_q, state_d;
  assign pipe_we = bus.WB_WB[WB_REGWRITE] && bus.WB_writeReg != REG_ZERO;
  assign pop = !pipe_we && !empty;
  // writes to r0 are acknowledged but never stored
  assign keep = bus.lu_valid && !full && bus.lu_reg != REG_ZERO;
  assign cnt_nxt = count + CW'(keep) - CW'(pop);
  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (keep),
    .pop   (pop),
    .wdata ({bus.lu_reg, bus.lu_data}),
    .rdata (head),
    .count (count),
    .full  (full),
    .empty (empty),
    .q0    (bus.id_rs),
    .q1    (bus.id_rt),
    .m0    (bus.pend_rs),
    .m1    (bus.pend_rt)
  );
  assign bus.lu_ready = !full;
  assign bus.rf_we    = rst && (pipe_we || pop);
  assign bus.rf_waddr = pipe_we ? bus.WB_writeReg : head[36:32];
  assign bus.rf_wdata = pipe_we ? (bus.WB_WB[WB_MEMTOREG] ? bus.WB_DM_out : bus.WB_ALU_out) : head[31:0];
  assign bus.stall_req = state_q == STALL;
  always_comb begin
    starve_d = (pop || empty) ? '0 : (starve_q == SW'(STARVE_MAX) ? starve_q : starve_q + 1'b1);
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = keep ? PEND : IDLE;
      PEND:    state_d = cnt_nxt == '0 ? IDLE : (!pop && starve_q == SW'(STARVE_MAX - 1)) ? STALL : PEND;
      STALL:   state_d = !pop ? STALL : cnt_nxt != '0 ? PEND : IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      starve_q <= '0;
    end else begin
      state_q <= state_d;
      starve_q <= starve_d;
    end
  end
endmodule
